display_timing_ctrl: RTL

Parametrised, frame-synchronous video timing controller for the display subsystem, running in the pixel clock domain between the register map and the output transmitters (HDMI/DP/DSI). It generates DE/HSYNC/VSYNC, frame/line markers and pixel coordinates from programmable porch/sync values. Its additions are shadowed configuration committed only at frame boundaries, graceful stop at end of frame, a line-match interrupt and per-output gating for NUM_OUTPUTS sinks.

---
 rtl/display_timing_ctrl_if.sv | 38 +++
 rtl/display_timing_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/display_timing_ctrl_if.sv
// rtl/display_timing_ctrl_if.sv - configuration and timing bundle between the register map and the timing controller
interface display_timing_ctrl_if #(
  parameter int CNT_WIDTH       = 13,
  parameter int NUM_OUTPUTS     = 3,
  parameter int FRAME_CNT_WIDTH = 16
);
  logic                       enable;
  logic [CNT_WIDTH-1:0]       cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
  logic [CNT_WIDTH-1:0]       cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
  logic                       cfg_hs_pol, cfg_vs_pol;
  logic [CNT_WIDTH-1:0]       cfg_line_irq;
  logic [NUM_OUTPUTS-1:0]     cfg_out_en;
  logic                       cfg_update;
  logic                       cfg_pending, cfg_err, busy;
  logic                       pixel_de, pixel_hsync, pixel_vsync;
  logic                       frame_start, line_start, line_irq;
  logic [CNT_WIDTH-1:0]       h_pos, v_pos;
  logic [FRAME_CNT_WIDTH-1:0] frame_count;
  logic [NUM_OUTPUTS-1:0]     out_de, out_hsync, out_vsync;

  modport master (
    output enable, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
           cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp,
           cfg_hs_pol, cfg_vs_pol, cfg_line_irq, cfg_out_en, cfg_update,
    input  cfg_pending, cfg_err, busy, pixel_de, pixel_hsync, pixel_vsync,
           frame_start, line_start, line_irq, h_pos, v_pos, frame_count,
           out_de, out_hsync, out_vsync
  );

  modport slave (
    input  enable, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
           cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp,
           cfg_hs_pol, cfg_vs_pol, cfg_line_irq, cfg_out_en, cfg_update,
    output cfg_pending, cfg_err, busy, pixel_de, pixel_hsync, pixel_vsync,
           frame_start, line_start, line_irq, h_pos, v_pos, frame_count,
           out_de, out_hsync, out_vsync
  );
endinterface

// File: rtl/display_timing_ctrl.sv
// rtl/display_timing_ctrl.sv - frame-synchronous video timing generator with shadowed, frame-boundary configuration
module display_timing_ctrl #(
  parameter int CNT_WIDTH       = 13,
  parameter int NUM_OUTPUTS     = 3,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input logic                  pixel_clk,
  input logic                  rst_n,
  display_timing_ctrl_if.slave tim
);
  localparam int TW = CNT_WIDTH + 2;
  localparam logic [TW-1:0] TOT_MAX = {2'b01, {CNT_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  typedef struct packed {
    logic [CNT_WIDTH-1:0]   ha, hfp, hs, hbp, va, vfp, vs, vbp, line_irq;
    logic                   hs_pol, vs_pol;
    logic [NUM_OUTPUTS-1:0] out_en;
  } shadow_t;

  function automatic logic [TW-1:0] ext(input logic [CNT_WIDTH-1:0] x);
    return {2'b00, x};
  endfunction

  state_e               state_q, state_d;
  shadow_t              sh_q, cfg_in;
  logic [CNT_WIDTH-1:0] h_q, h_d, v_q, v_d;
  logic                 pending_q, pending_d, err_q, err_d;
  logic                 try_commit, cfg_ok, h_last, v_last, last_pix;
  logic [TW-1:0]        cfg_htot, cfg_vtot, sh_htot, sh_vtot;

  always_comb begin
    cfg_in          = '0;
    cfg_in.ha       = tim.cfg_h_active;
    cfg_in.hfp      = tim.cfg_h_fp;
    cfg_in.hs       = tim.cfg_h_sync;
    cfg_in.hbp      = tim.cfg_h_bp;
    cfg_in.va       = tim.cfg_v_active;
    cfg_in.vfp      = tim.cfg_v_fp;
    cfg_in.vs       = tim.cfg_v_sync;
    cfg_in.vbp      = tim.cfg_v_bp;
    cfg_in.line_irq = tim.cfg_line_irq;
    cfg_in.hs_pol   = tim.cfg_hs_pol;
    cfg_in.vs_pol   = tim.cfg_vs_pol;
    cfg_in.out_en   = tim.cfg_out_en;
  end

  // Totals carry two extra bits so a sum just past 2^CNT_WIDTH is still detectable
  assign cfg_htot = ext(cfg_in.ha) + ext(cfg_in.hfp) + ext(cfg_in.hs) + ext(cfg_in.hbp);
  assign cfg_vtot = ext(cfg_in.va) + ext(cfg_in.vfp) + ext(cfg_in.vs) + ext(cfg_in.vbp);
  assign sh_htot  = ext(sh_q.ha) + ext(sh_q.hfp) + ext(sh_q.hs) + ext(sh_q.hbp);
  assign sh_vtot  = ext(sh_q.va) + ext(sh_q.vfp) + ext(sh_q.vs) + ext(sh_q.vbp);

  assign cfg_ok = (|cfg_in.ha) && (|cfg_in.hs) && (|cfg_in.va) && (|cfg_in.vs) &&
                  (cfg_htot <= TOT_MAX) && (cfg_vtot <= TOT_MAX);

  assign h_last   = ext(h_q) == (sh_htot - TW'(1));
  assign v_last   = ext(v_q) == (sh_vtot - TW'(1));
  assign last_pix = h_last && v_last;

  always_comb begin
    state_d    = state_q;
    h_d        = h_q;
    v_d        = v_q;
    try_commit = 1'b0;
    unique case (state_q)
      IDLE: begin
        h_d = '0;
        v_d = '0;
        if (tim.enable) begin
          try_commit = 1'b1;
          if (cfg_ok) state_d = RUN;
        end
      end
      RUN, DRAIN: begin
        try_commit = last_pix && (pending_q || tim.cfg_update);
        if (h_last) begin
          h_d = '0;
          v_d = v_last ? '0 : v_q + CNT_WIDTH'(1);
        end else begin
          h_d = h_q + CNT_WIDTH'(1);
        end
        // Dropping enable on the very last pixel stops here rather than draining a whole extra frame
        if (tim.enable)    state_d = RUN;
        else if (last_pix) state_d = IDLE;
        else               state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
    err_d     = try_commit && !cfg_ok;
    pending_d = try_commit ? 1'b0 : (tim.cfg_update ? 1'b1 : pending_q);
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      h_q         <= '0;
      v_q         <= '0;
      pending_q   <= 1'b0;
      err_q       <= 1'b0;
      sh_q        <= '0;
      sh_q.hs_pol <= 1'b1;
      sh_q.vs_pol <= 1'b1;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      if (try_commit && cfg_ok) sh_q <= cfg_in;
    end
  end

  // Output stage: registered decode of the counter stage, so every output lines up with h_pos/v_pos
  logic                       run, hs_act, vs_act;
  logic [TW-1:0]              hs_start, vs_start;
  logic                       de_d, hsync_d, vsync_d, ls_d, fs_d, li_d;
  logic                       de_q, hsync_q, vsync_q, ls_q, fs_q, li_q, busy_q;
  logic [CNT_WIDTH-1:0]       h_pos_q, v_pos_q;
  logic [FRAME_CNT_WIDTH-1:0] fc_d, fc_q;
  logic [NUM_OUTPUTS-1:0]     out_de_d, out_hs_d, out_vs_d, out_de_q, out_hs_q, out_vs_q;

  always_comb begin
    run      = state_q != IDLE;
    hs_start = ext(sh_q.ha) + ext(sh_q.hfp);
    vs_start = ext(sh_q.va) + ext(sh_q.vfp);
    hs_act   = run && (ext(h_q) >= hs_start) && (ext(h_q) < hs_start + ext(sh_q.hs));
    vs_act   = run && (ext(v_q) >= vs_start) && (ext(v_q) < vs_start + ext(sh_q.vs));
    de_d     = run && (h_q < sh_q.ha) && (v_q < sh_q.va);
    hsync_d  = sh_q.hs_pol ? hs_act : !hs_act;
    vsync_d  = sh_q.vs_pol ? vs_act : !vs_act;
    ls_d     = run && (h_q == '0);
    fs_d     = ls_d && (v_q == '0);
    li_d     = ls_d && (v_q == sh_q.line_irq);
    fc_d     = fc_q + FRAME_CNT_WIDTH'(fs_d);
    out_de_d = {NUM_OUTPUTS{de_d}} & sh_q.out_en;
    out_hs_d = (sh_q.out_en & {NUM_OUTPUTS{hsync_d}}) | (~sh_q.out_en & {NUM_OUTPUTS{~sh_q.hs_pol}});
    out_vs_d = (sh_q.out_en & {NUM_OUTPUTS{vsync_d}}) | (~sh_q.out_en & {NUM_OUTPUTS{~sh_q.vs_pol}});
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q     <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      li_q     <= 1'b0;
      busy_q   <= 1'b0;
      h_pos_q  <= '0;
      v_pos_q  <= '0;
      fc_q     <= '0;
      out_de_q <= '0;
      out_hs_q <= '0;
      out_vs_q <= '0;
    end else begin
      de_q     <= de_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
      li_q     <= li_d;
      busy_q   <= run;
      h_pos_q  <= h_q;
      v_pos_q  <= v_q;
      fc_q     <= fc_d;
      out_de_q <= out_de_d;
      out_hs_q <= out_hs_d;
      out_vs_q <= out_vs_d;
    end
  end

  assign tim.cfg_pending = pending_q;
  assign tim.cfg_err     = err_q;
  assign tim.busy        = busy_q;
  assign tim.pixel_de    = de_q;
  assign tim.pixel_hsync = hsync_q;
  assign tim.pixel_vsync = vsync_q;
  assign tim.frame_start = fs_q;
  assign tim.line_start  = ls_q;
  assign tim.line_irq    = li_q;
  assign tim.h_pos       = h_pos_q;
  assign tim.v_pos       = v_pos_q;
  assign tim.frame_count = fc_q;
  assign tim.out_de      = out_de_q;
  assign tim.out_hsync   = out_hs_q;
  assign tim.out_vsync   = out_vs_q;
endmodule
